ddr_axi4_upsizer: RTL
=====================

DDR_AXI4_UPSIZER -- requirements
Module: ddr_axi4_upsizer

Interface
REQ-001 Parameters: ID_W, default 16, AXI ID width on both sides; SA_W, default 32, narrow-side address width.
REQ-002 clk_main_a0  in  1  sole clock; all state on rising edge.
REQ-003 rst_main_n  in  1  reset, asynchronous, active-low.
REQ-004 s_aw{valid,ready,addr[SA_W],len[8],id[ID_W]}  in/out  narrow write-address channel from the simulator-shim memory master.
REQ-005 s_w{valid,ready,data[64],strb[8],last}  in/out  narrow write data.
REQ-006 s_b{valid,ready,resp[2],id[ID_W]}  out/in  narrow write response.
REQ-007 s_ar{valid,ready,addr[SA_W],len[8],id[ID_W]}  in/out  narrow read address.
REQ-008 s_r{valid,ready,data[64],resp[2],id[ID_W],last}  out/in  narrow read data.
REQ-009 m_aw{valid,ready,addr[64],len[8],size[3],id[ID_W]}  out/in  wide DDR write address.
REQ-010 m_w{valid,ready,data[512],strb[64],last,id[ID_W]}  out/in  wide DDR write data.
REQ-011 m_b{valid,ready,resp[2],id[ID_W]}  in/out  wide write response.
REQ-012 m_ar{valid,ready,addr[64],len[8],size[3],id[ID_W]} / m_r{valid,ready,data[512],resp[2],id[ID_W],last}  wide DDR read channels.

Function
REQ-013 Every narrow burst SHALL be executed as len+1 sequential single-beat wide transactions: m_*len=0, m_*size=3'b110, m_wlast=1, m_*id=latched s_*id.
REQ-014 Beat address SHALL start at latched s_addr and increment by 8 per beat, wrapping modulo 2^SA_W; no 4 KB check.
REQ-015 Wide address SHALL be {zero-extend, beat_addr[SA_W-1:6], 6'b0}; lane = beat_addr[5:3].
REQ-016 Burst type, size, s_wlast SHALL be ignored; beat count comes solely from latched len.
REQ-017 Write FSM states WIDLE, WDATA, WISSUE, WRESP, WBRESP.
REQ-018 WIDLE: s_awready=1; on handshake latch addr/len/id, clear beat count and merged resp -> WDATA.
REQ-019 WDATA: s_wready=1; on handshake capture data and strb -> WISSUE.
REQ-020 WISSUE: m_awvalid and m_wvalid asserted together; m_wdata = captured 64-bit word replicated 8x; m_wstrb = strb shifted to bits [lane*8+7:lane*8], zero elsewhere; each valid drops independently on its handshake; when both done -> WRESP.
REQ-021 WRESP: m_bready=1; on m_b handshake merged resp = max(merged, m_bresp); if count==len -> WBRESP else count++, addr+=8 -> WDATA.
REQ-022 WBRESP: s_bvalid=1, s_bresp=merged, s_bid=latched id; on s_bready -> WIDLE.
REQ-023 Read FSM states RIDLE, RADDR, RDATA, RRET.
REQ-024 RIDLE: s_arready=1; on handshake latch addr/len/id, clear count -> RADDR.
REQ-025 RADDR: m_arvalid=1; on m_arready -> RDATA.
REQ-026 RDATA: m_rready=1; on m_r handshake capture m_rdata[lane*64+63:lane*64] and m_rresp -> RRET.
REQ-027 RRET: s_rvalid=1, s_rid=latched id, s_rlast=(count==len); on s_rready: if last -> RIDLE else count++, addr+=8 -> RADDR.
REQ-028 Read and write FSMs SHALL be fully independent; one outstanding burst per direction; m_rid/m_bid ignored.
REQ-029 All s_* and m_* outputs SHALL be registered or decoded from FSM state only; no combinational ready-to-ready or valid-to-valid path between sides.
REQ-030 Minimum per-beat latency: write 3 cycles s_w handshake to next s_wready; read 3 cycles m_ar to s_rvalid.

Reset
REQ-031 While rst_main_n=0, FSMs SHALL be WIDLE/RIDLE, all valid and ready outputs 0 except s_awready=s_arready=0, all data/addr/id/len registers 0.
REQ-032 First cycle after release SHALL assert s_awready=s_arready=1; in-flight bursts at reset assertion SHALL be abandoned without response.

Verification
REQ-033 Write addr 0x1008 len 0 data 0xDEADBEEF_CAFEF00D strb 0xFF -> one m_aw addr 0x1000 size 6; m_wstrb = 0xFF<<8; one s_b resp OKAY id echoed.
REQ-034 Write addr 0x38 len 2 -> three m_aw at 0x00, 0x40, 0x40; lanes 7,0,1; second m_bresp SLVERR -> single s_bresp SLVERR.
REQ-035 Read addr 0x2010 len 3, DDR returns distinct lane patterns -> four s_r beats lanes 2..5, s_rlast only on beat 4.
REQ-036 Concurrent write and read bursts with random m_*ready/s_*ready backpressure -> both complete, scoreboard data matches, no dropped or duplicated beats.
REQ-037 Assert rst_main_n low mid-read in RRET -> next cycle s_rvalid=0, m_arvalid=0; after release new read completes normally.
REQ-038 Write at addr 0xFFFF_FFF8 len 1 -> second beat addr 0x0000_0000.

Source files
------------

// File: rtl/ddr_axi4_upsizer.sv
`default_nettype none
// ============================================================================
// Module   : ddr_axi4_upsizer
// Brief    : Bridges a 64-bit AXI4 shim master onto a 512-bit DDR port by
//            issuing one single-beat wide transaction per narrow beat.
// Revision : 1.0
// ============================================================================
module ddr_axi4_upsizer #(
    parameter int ID_W = 16,
    parameter int SA_W = 32
) (
    input  logic            clk_main_a0,
    input  logic            rst_main_n,
    // narrow write address
    input  logic            s_awvalid,
    output logic            s_awready,
    input  logic [SA_W-1:0] s_awaddr,
    input  logic [7:0]      s_awlen,
    input  logic [ID_W-1:0] s_awid,
    // narrow write data
    input  logic            s_wvalid,
    output logic            s_wready,
    input  logic [63:0]     s_wdata,
    input  logic [7:0]      s_wstrb,
    input  logic            s_wlast,
    // narrow write response
    output logic            s_bvalid,
    input  logic            s_bready,
    output logic [1:0]      s_bresp,
    output logic [ID_W-1:0] s_bid,
    // narrow read address
    input  logic            s_arvalid,
    output logic            s_arready,
    input  logic [SA_W-1:0] s_araddr,
    input  logic [7:0]      s_arlen,
    input  logic [ID_W-1:0] s_arid,
    // narrow read data
    output logic            s_rvalid,
    input  logic            s_rready,
    output logic [63:0]     s_rdata,
    output logic [1:0]      s_rresp,
    output logic [ID_W-1:0] s_rid,
    output logic            s_rlast,
    // wide write address
    output logic            m_awvalid,
    input  logic            m_awready,
    output logic [63:0]     m_awaddr,
    output logic [7:0]      m_awlen,
    output logic [2:0]      m_awsize,
    output logic [ID_W-1:0] m_awid,
    // wide write data
    output logic            m_wvalid,
    input  logic            m_wready,
    output logic [511:0]    m_wdata,
    output logic [63:0]     m_wstrb,
    output logic            m_wlast,
    output logic [ID_W-1:0] m_wid,
    // wide write response
    input  logic            m_bvalid,
    output logic            m_bready,
    input  logic [1:0]      m_bresp,
    input  logic [ID_W-1:0] m_bid,
    // wide read address
    output logic            m_arvalid,
    input  logic            m_arready,
    output logic [63:0]     m_araddr,
    output logic [7:0]      m_arlen,
    output logic [2:0]      m_arsize,
    output logic [ID_W-1:0] m_arid,
    // wide read data
    input  logic            m_rvalid,
    output logic            m_rready,
    input  logic [511:0]    m_rdata,
    input  logic [1:0]      m_rresp,
    input  logic [ID_W-1:0] m_rid,
    input  logic            m_rlast
);

    localparam logic [2:0] c_WIDLE  = 3'd0;
    localparam logic [2:0] c_WDATA  = 3'd1;
    localparam logic [2:0] c_WISSUE = 3'd2;
    localparam logic [2:0] c_WRESP  = 3'd3;
    localparam logic [2:0] c_WBRESP = 3'd4;

    localparam logic [1:0] c_RIDLE  = 2'd0;
    localparam logic [1:0] c_RADDR  = 2'd1;
    localparam logic [1:0] c_RDATA  = 2'd2;
    localparam logic [1:0] c_RRET   = 2'd3;

    localparam logic [2:0] c_WIDE_SIZE = 3'b110;

    logic            r_out_en;

    logic [2:0]      r_wstate;
    logic [SA_W-1:0] r_waddr;
    logic [7:0]      r_wlen;
    logic [ID_W-1:0] r_wid;
    logic [7:0]      r_wcnt;
    logic [1:0]      r_wresp;
    logic [63:0]     r_wdata;
    logic [7:0]      r_wstrb;
    logic            r_aw_pend;
    logic            r_w_pend;

    logic [1:0]      r_rstate;
    logic [SA_W-1:0] r_raddr;
    logic [7:0]      r_rlen;
    logic [ID_W-1:0] r_rid;
    logic [7:0]      r_rcnt;
    logic [63:0]     r_rdata;
    logic [1:0]      r_rresp;

    logic            w_unused;

    // Holds the idle readies low through reset and releases them one edge later.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            r_out_en <= 1'b0;
        end else begin
            r_out_en <= 1'b1;
        end
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            r_wstate  <= c_WIDLE;
            r_waddr   <= '0;
            r_wlen    <= '0;
            r_wid     <= '0;
            r_wcnt    <= '0;
            r_wresp   <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_aw_pend <= 1'b0;
            r_w_pend  <= 1'b0;
        end else begin
            case (r_wstate)
                c_WIDLE: begin
                    if (s_awvalid && s_awready) begin
                        r_waddr  <= s_awaddr;
                        r_wlen   <= s_awlen;
                        r_wid    <= s_awid;
                        r_wcnt   <= '0;
                        r_wresp  <= '0;
                        r_wstate <= c_WDATA;
                    end
                end
                c_WDATA: begin
                    if (s_wvalid) begin
                        r_wdata   <= s_wdata;
                        r_wstrb   <= s_wstrb;
                        r_aw_pend <= 1'b1;
                        r_w_pend  <= 1'b1;
                        r_wstate  <= c_WISSUE;
                    end
                end
                c_WISSUE: begin
                    // Address and data channels retire independently.
                    if (m_awready) begin
                        r_aw_pend <= 1'b0;
                    end
                    if (m_wready) begin
                        r_w_pend <= 1'b0;
                    end
                    if ((!r_aw_pend || m_awready) && (!r_w_pend || m_wready)) begin
                        r_wstate <= c_WRESP;
                    end
                end
                c_WRESP: begin
                    if (m_bvalid) begin
                        if (m_bresp > r_wresp) begin
                            r_wresp <= m_bresp;
                        end
                        if (r_wcnt == r_wlen) begin
                            r_wstate <= c_WBRESP;
                        end else begin
                            r_wcnt   <= r_wcnt + 8'd1;
                            r_waddr  <= r_waddr + SA_W'(8);
                            r_wstate <= c_WDATA;
                        end
                    end
                end
                c_WBRESP: begin
                    if (s_bready) begin
                        r_wstate <= c_WIDLE;
                    end
                end
                default: begin
                    r_wstate <= c_WIDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            r_rstate <= c_RIDLE;
            r_raddr  <= '0;
            r_rlen   <= '0;
            r_rid    <= '0;
            r_rcnt   <= '0;
            r_rdata  <= '0;
            r_rresp  <= '0;
        end else begin
            case (r_rstate)
                c_RIDLE: begin
                    if (s_arvalid && s_arready) begin
                        r_raddr  <= s_araddr;
                        r_rlen   <= s_arlen;
                        r_rid    <= s_arid;
                        r_rcnt   <= '0;
                        r_rstate <= c_RADDR;
                    end
                end
                c_RADDR: begin
                    if (m_arready) begin
                        r_rstate <= c_RDATA;
                    end
                end
                c_RDATA: begin
                    if (m_rvalid) begin
                        r_rdata  <= m_rdata[{r_raddr[5:3], 6'b000000} +: 64];
                        r_rresp  <= m_rresp;
                        r_rstate <= c_RRET;
                    end
                end
                c_RRET: begin
                    if (s_rready) begin
                        if (r_rcnt == r_rlen) begin
                            r_rstate <= c_RIDLE;
                        end else begin
                            r_rcnt   <= r_rcnt + 8'd1;
                            r_raddr  <= r_raddr + SA_W'(8);
                            r_rstate <= c_RADDR;
                        end
                    end
                end
                default: begin
                    r_rstate <= c_RIDLE;
                end
            endcase
        end
    end

    assign s_awready = r_out_en && (r_wstate == c_WIDLE);
    assign s_wready  = (r_wstate == c_WDATA);
    assign s_bvalid  = (r_wstate == c_WBRESP);
    assign s_bresp   = r_wresp;
    assign s_bid     = r_wid;

    assign m_awvalid = r_aw_pend;
    assign m_awaddr  = 64'({r_waddr[SA_W-1:6], 6'b000000});
    assign m_awlen   = 8'd0;
    assign m_awsize  = c_WIDE_SIZE;
    assign m_awid    = r_wid;

    // Narrow word sits in every lane; the strobe selects the target lane.
    assign m_wvalid  = r_w_pend;
    assign m_wdata   = {8{r_wdata}};
    assign m_wstrb   = {56'd0, r_wstrb} << {r_waddr[5:3], 3'b000};
    assign m_wlast   = 1'b1;
    assign m_wid     = r_wid;
    assign m_bready  = (r_wstate == c_WRESP);

    assign s_arready = r_out_en && (r_rstate == c_RIDLE);
    assign s_rvalid  = (r_rstate == c_RRET);
    assign s_rdata   = r_rdata;
    assign s_rresp   = r_rresp;
    assign s_rid     = r_rid;
    assign s_rlast   = (r_rstate == c_RRET) && (r_rcnt == r_rlen);

    assign m_arvalid = (r_rstate == c_RADDR);
    assign m_araddr  = 64'({r_raddr[SA_W-1:6], 6'b000000});
    assign m_arlen   = 8'd0;
    assign m_arsize  = c_WIDE_SIZE;
    assign m_arid    = r_rid;
    assign m_rready  = (r_rstate == c_RDATA);

    // Burst framing and returned IDs carry no information for this bridge.
    assign w_unused = ^{s_wlast, m_bid, m_rid, m_rlast};

endmodule
`default_nettype wire
